// File: rtl/alu_word_sequencer_pkg.sv
// Shared op codes, flag bit positions and FSM states for the multi-word ALU sequencer.
package alu_word_sequencer_pkg;

  localparam int unsigned OpW = 4;

  localparam logic [OpW-1:0] OP_ADD = 4'd0;
  localparam logic [OpW-1:0] OP_SUB = 4'd1;
  localparam logic [OpW-1:0] OP_AND = 4'd2;
  localparam logic [OpW-1:0] OP_OR  = 4'd3;
  localparam logic [OpW-1:0] OP_XOR = 4'd4;

  // Flag vector layout {V,N,C,Z}
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_valid(input logic [OpW-1:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/alu_word_sequencer_alu.sv
// Single-word combinational ALU shared by the sequencer; only IFlags[C] is consumed.
module alu_word_sequencer_alu
  import alu_word_sequencer_pkg::*;
#(
  parameter int unsigned DataWidth = 8
) (
  input  logic [DataWidth-1:0] A,
  input  logic [DataWidth-1:0] B,
  input  logic [OpW-1:0]       FuncOp,
  input  logic [3:0]           IFlags,
  output logic [DataWidth-1:0] Y,
  output logic [3:0]           OFlags
);

  localparam int unsigned SumW = DataWidth + 1;
  localparam int unsigned Msb  = DataWidth - 1;

  logic [SumW-1:0] sum;
  logic            c_out;
  logic            v_out;
  logic            unused_iflags;

  assign unused_iflags = ^{IFlags[FLAG_V], IFlags[FLAG_N], IFlags[FLAG_Z]};

  always_comb begin
    sum    = '0;
    Y      = '0;
    c_out  = 1'b0;
    v_out  = 1'b0;
    OFlags = '0;
    case (FuncOp)
      OP_ADD: begin
        sum   = SumW'(A) + SumW'(B) + SumW'(IFlags[FLAG_C]);
        Y     = sum[Msb:0];
        c_out = sum[DataWidth];
        v_out = (A[Msb] == B[Msb]) && (Y[Msb] != A[Msb]);
      end
      // Plain subtract without borrow-in; C reports no-borrow
      OP_SUB: begin
        sum   = SumW'(A) - SumW'(B);
        Y     = sum[Msb:0];
        c_out = ~sum[DataWidth];
        v_out = (A[Msb] != B[Msb]) && (Y[Msb] != A[Msb]);
      end
      OP_AND:  Y = A & B;
      OP_OR:   Y = A | B;
      OP_XOR:  Y = A ^ B;
      default: Y = '0;
    endcase
    OFlags[FLAG_V] = v_out;
    OFlags[FLAG_N] = Y[Msb];
    OFlags[FLAG_C] = c_out;
    OFlags[FLAG_Z] = (Y == '0);
  end

endmodule

// File: rtl/alu_word_sequencer.sv
// Runs one Words x DataWidth operation through the shared ALU, LSB word first, chaining carry.
// Optional macro ALU_SEQ_SBC_EN: Sub takes CarryIn as word-0 not-borrow instead of forcing 1.
module alu_word_sequencer
  import alu_word_sequencer_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Words     = 4,
  parameter int unsigned FlagBits  = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic [OpW-1:0]               Op,
  input  logic                         CarryIn,
  input  logic [DataWidth*Words-1:0]   OpA,
  input  logic [DataWidth*Words-1:0]   OpB,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Err,
  output logic [DataWidth*Words-1:0]   Result,
  output logic [FlagBits-1:0]          Flags
);

  localparam int unsigned WideW = DataWidth * Words;
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned Msb   = DataWidth - 1;

  state_t              state_q;
  logic [IdxW-1:0]     idx_q;
  logic [OpW-1:0]      op_q;
  logic                cin_q;
  logic                carry_q;
  logic                zacc_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [WideW-1:0]    a_q;
  logic [WideW-1:0]    b_q;
  logic [WideW-1:0]    result_q;
  logic [FlagBits-1:0] flags_q;
  logic [FlagBits-1:0] flags_d;

  logic [31:0]          word_lsb;
  logic [DataWidth-1:0] a_word;
  logic [DataWidth-1:0] b_word;
  logic [DataWidth-1:0] alu_b;
  logic [DataWidth-1:0] alu_y;
  logic [OpW-1:0]       alu_op;
  logic [3:0]           alu_iflags;
  logic [3:0]           alu_oflags;
  logic                 is_sub;
  logic                 is_arith;
  logic                 first_cin;
  logic                 last_word;

  // Word slicing and ALU drive; Sub is issued as Add of the inverted B word
  always_comb begin
    word_lsb  = 32'(idx_q) * 32'(DataWidth);
    a_word    = a_q[word_lsb +: DataWidth];
    b_word    = b_q[word_lsb +: DataWidth];
    is_sub    = (op_q == OP_SUB);
    is_arith  = (op_q == OP_ADD) || is_sub;
    alu_b     = is_sub ? ~b_word : b_word;
    alu_op    = is_sub ? OP_ADD : op_q;
    last_word = (idx_q == IdxW'(Words - 1));
`ifdef ALU_SEQ_SBC_EN
    first_cin = cin_q;
`else
    first_cin = is_sub ? 1'b1 : cin_q;
`endif
    alu_iflags         = '0;
    alu_iflags[FLAG_C] = (idx_q == '0) ? first_cin : carry_q;
  end

  // Aggregate flags loaded on the top-word write
  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_Z] = zacc_q & alu_oflags[FLAG_Z];
    if (is_arith) begin
      flags_d[FLAG_C] = alu_oflags[FLAG_C];
      flags_d[FLAG_N] = alu_oflags[FLAG_N];
      flags_d[FLAG_V] = alu_oflags[FLAG_V];
    end else begin
      flags_d[FLAG_N] = alu_y[Msb];
    end
  end

  alu_word_sequencer_alu #(
    .DataWidth(DataWidth)
  ) u_alu (
    .A      (a_word),
    .B      (alu_b),
    .FuncOp (alu_op),
    .IFlags (alu_iflags),
    .Y      (alu_y),
    .OFlags (alu_oflags)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            a_q     <= OpA;
            b_q     <= OpB;
            op_q    <= Op;
            cin_q   <= CarryIn;
            idx_q   <= '0;
            zacc_q  <= 1'b1;
            carry_q <= 1'b0;
            if (op_valid(Op)) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              err_q   <= 1'b0;
            end else begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              result_q <= '0;
              flags_q  <= '0;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          result_q[word_lsb +: DataWidth] <= alu_y;
          carry_q <= alu_oflags[FLAG_C];
          zacc_q  <= zacc_q & alu_oflags[FLAG_Z];
          if (last_word) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            flags_q <= flags_d;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Err    = err_q;
  assign Result = result_q;
  assign Flags  = flags_q;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Self-checking bench for alu_word_sequencer (8-bit words, 4 words) with a wide-arithmetic reference model.
module tb_alu_word_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [3:0]  Op;
  logic        CarryIn;
  logic [31:0] OpA;
  logic [31:0] OpB;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic [31:0] Result;
  logic [3:0]  Flags;

  int checks = 0;
  int errors = 0;

  localparam longint SMax = 64'sd2147483647;
  localparam longint SMin = -64'sd2147483648;

  alu_word_sequencer #(
    .DataWidth(8),
    .Words    (4),
    .FlagBits (4)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Op      (Op),
    .CarryIn (CarryIn),
    .OpA     (OpA),
    .OpB     (OpB),
    .Busy    (Busy),
    .Done    (Done),
    .Err     (Err),
    .Result  (Result),
    .Flags   (Flags)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Whole-width reference: flags returned as {V,N,C,Z}
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, output logic [31:0] r, output logic [3:0] f,
                                output logic e);
    longint ua, ub, sa, sb, ur, sr, bin;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; f = '0; e = 1'b0;
`ifdef ALU_SEQ_SBC_EN
    bin = cin ? 0 : 1;
`else
    bin = 0;
`endif
    case (op)
      4'd0: begin
        ur = ua + ub + longint'(cin);
        sr = sa + sb + longint'(cin);
        r = 32'(ur);
        f[1] = (ur > 64'sd4294967295);
        f[3] = (sr > SMax) || (sr < SMin);
      end
      4'd1: begin
        ur = ua - ub - bin;
        sr = sa - sb - bin;
        r = 32'(ur);
        f[1] = (ur >= 0);
        f[3] = (sr > SMax) || (sr < SMin);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: e = 1'b1;
    endcase
    if (!e) begin
      f[2] = r[31];
      f[0] = (r == 32'd0);
    end
  endfunction

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cin);
    Op = op; OpA = a; OpB = b; CarryIn = cin; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Called one negedge after the accept edge; edges counts from the accept edge
  task automatic wait_done(output int edges, output int busy_cnt, output bit to);
    edges = 1; busy_cnt = 0; to = 1'b0;
    while (Done !== 1'b1) begin
      if (edges >= 20) begin
        to = 1'b1;
        return;
      end
      busy_cnt += (Busy === 1'b1) ? 1 : 0;
      @(negedge Clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Op = '0; CarryIn = 1'b0; OpA = '0; OpB = '0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({Busy, Done, Err, Result, Flags} !== 39'd0) begin
      errors++;
      $display("FAIL reset_values got %h want 0", {Busy, Done, Err, Result, Flags});
    end
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_add();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic [31:0] er [3];
    logic [3:0]  ef [3];
    int e, bc; bit to;
    ta[0] = 32'h000000FF; tb[0] = 32'h00000001; er[0] = 32'h00000100; ef[0] = 4'b0000;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'h00000001; er[1] = 32'h00000000; ef[1] = 4'b0011;
    ta[2] = 32'h7FFFFFFF; tb[2] = 32'h00000001; er[2] = 32'h80000000; ef[2] = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      start_op(4'd0, ta[i], tb[i], 1'b0);
      wait_done(e, bc, to);
      checks++;
      if (to || e != 5 || bc != 4) begin
        errors++;
        $display("FAIL add_latency[%0d] got edges=%0d busy=%0d timeout=%0d want edges=5 busy=4", i, e, bc, to);
      end
      checks++;
      if ({Result, Flags, Err} !== {er[i], ef[i], 1'b0}) begin
        errors++;
        $display("FAIL add_result[%0d] got %h/%b/%b want %h/%b/0", i, Result, Flags, Err, er[i], ef[i]);
      end
      @(negedge Clk);
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0 || Result !== er[i] || Flags !== ef[i]) begin
        errors++;
        $display("FAIL add_hold[%0d] got done=%b busy=%b %h/%b want 0 0 %h/%b", i, Done, Busy, Result, Flags, er[i], ef[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic        tc [3];
    logic [31:0] er [3];
    logic [3:0]  ef [3];
    int e, bc; bit to;
    ta[0] = 32'h00000000; tb[0] = 32'h00000001; tc[0] = 1'b1; er[0] = 32'hFFFFFFFF; ef[0] = 4'b0100;
    ta[1] = 32'h12345678; tb[1] = 32'h12345678; tc[1] = 1'b1; er[1] = 32'h00000000; ef[1] = 4'b0011;
    ta[2] = 32'h12345678; tb[2] = 32'h12345678; tc[2] = 1'b0;
`ifdef ALU_SEQ_SBC_EN
    er[2] = 32'hFFFFFFFF; ef[2] = 4'b0100;
`else
    er[2] = 32'h00000000; ef[2] = 4'b0011;
`endif
    for (int i = 0; i < 3; i++) begin
      start_op(4'd1, ta[i], tb[i], tc[i]);
      wait_done(e, bc, to);
      checks++;
      if (to || e != 5 || {Result, Flags, Err} !== {er[i], ef[i], 1'b0}) begin
        errors++;
        $display("FAIL sub[%0d] got edges=%0d %h/%b/%b want edges=5 %h/%b/0", i, e, Result, Flags, Err, er[i], ef[i]);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_logic();
    logic [3:0]  to_op [3];
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic [31:0] er [3];
    logic [3:0]  ef [3];
    int e, bc; bit to;
    to_op[0] = 4'd4; ta[0] = 32'hA5A5A5A5; tb[0] = 32'hA5A5A5A5; er[0] = 32'h00000000; ef[0] = 4'b0001;
    to_op[1] = 4'd3; ta[1] = 32'h80000000; tb[1] = 32'h00000000; er[1] = 32'h80000000; ef[1] = 4'b0100;
    to_op[2] = 4'd2; ta[2] = 32'hF0F0F0F0; tb[2] = 32'hFF00FF00; er[2] = 32'hF000F000; ef[2] = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      start_op(to_op[i], ta[i], tb[i], 1'b1);
      wait_done(e, bc, to);
      checks++;
      if (to || e != 5 || {Result, Flags, Err} !== {er[i], ef[i], 1'b0}) begin
        errors++;
        $display("FAIL logic[%0d] got edges=%0d %h/%b/%b want edges=5 %h/%b/0", i, e, Result, Flags, Err, er[i], ef[i]);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_invalid();
    int e, bc; bit to;
    start_op(4'd7, 32'hDEADBEEF, 32'h01234567, 1'b1);
    wait_done(e, bc, to);
    checks++;
    if (to || e != 1 || bc != 0) begin
      errors++;
      $display("FAIL invalid_latency got edges=%0d busy=%0d want edges=1 busy=0", e, bc);
    end
    checks++;
    if ({Result, Flags, Err} !== {32'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL invalid_outputs got %h/%b/%b want 00000000/0000/1", Result, Flags, Err);
    end
    @(negedge Clk);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Err !== 1'b1) begin
      errors++;
      $display("FAIL invalid_after got done=%b busy=%b err=%b want 0 0 1", Done, Busy, Err);
    end
  endtask

  task automatic test_busy_ignore();
    int e, bc; bit to;
    start_op(4'd0, 32'h11111111, 32'h22222222, 1'b0);
    Op = 4'd1; OpA = 32'hCAFEF00D; OpB = 32'h0BADBEEF; CarryIn = 1'b1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(e, bc, to);
    checks++;
    if (to || e != 4 || {Result, Flags, Err} !== {32'h33333333, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL busy_ignore got edges=%0d %h/%b/%b want edges=4 33333333/0000/0", e, Result, Flags, Err);
    end
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_queued got busy=%b done=%b want 0 0", Busy, Done);
    end
  endtask

  task automatic test_back_to_back();
    int e, bc; bit to;
    start_op(4'd0, 32'h00000001, 32'h00000002, 1'b1);
    wait_done(e, bc, to);
    checks++;
    if (to || Result !== 32'h00000004) begin
      errors++;
      $display("FAIL b2b_first got %h timeout=%0d want 00000004", Result, to);
    end
    start_op(4'd1, 32'h00000010, 32'h00000003, 1'b1);
    wait_done(e, bc, to);
    checks++;
    if (to || e != 5 || bc != 4 || {Result, Flags, Err} !== {32'h0000000D, 4'b0010, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second got edges=%0d busy=%0d %h/%b/%b want 5 4 0000000d/0010/0", e, bc, Result, Flags, Err);
    end
    @(negedge Clk);
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b, r;
    logic [3:0]  f;
    logic        cin, ee;
    int e, bc, we; bit to;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 5));
      if (op == 4'd5) op = 4'($urandom_range(5, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 4) == 0) b = ~a;
      cin = 1'($urandom_range(0, 1));
      model(op, a, b, cin, r, f, ee);
      we = ee ? 1 : 5;
      start_op(op, a, b, cin);
      wait_done(e, bc, to);
      checks++;
      if (to || e != we) begin
        errors++;
        $display("FAIL rand_latency[%0d] op=%0d got edges=%0d timeout=%0d want %0d", n, op, e, to, we);
      end
      checks++;
      if ({Result, Flags, Err} !== {r, f, ee}) begin
        errors++;
        $display("FAIL rand_result[%0d] op=%0d a=%h b=%h cin=%b got %h/%b/%b want %h/%b/%b",
                 n, op, a, b, cin, Result, Flags, Err, r, f, ee);
      end
      if ($urandom_range(0, 1) == 1) @(negedge Clk);
    end
    @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    int e, bc; bit to; bit seen;
    start_op(4'd0, 32'h01020304, 32'h10203040, 1'b0);
    repeat (2) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({Busy, Done, Err, Result, Flags} !== 39'd0) begin
      errors++;
      $display("FAIL reset_mid_async got %h want 0", {Busy, Done, Err, Result, Flags});
    end
    @(negedge Clk);
    Reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (Done === 1'b1 || Busy === 1'b1) seen = 1'b1;
      @(negedge Clk);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_no_done got activity=1 want 0");
    end
    start_op(4'd0, 32'h01020304, 32'h10203040, 1'b0);
    wait_done(e, bc, to);
    checks++;
    if (to || e != 5 || {Result, Flags, Err} !== {32'h11223344, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_restart got edges=%0d %h/%b/%b want 5 11223344/0000/0", e, Result, Flags, Err);
    end
    @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_invalid();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
